if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding instruction-memory read feeding a
// 2-entry in-order queue toward decode, with not-taken prediction and redirect flush.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, count_pop;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    fq_entry_t       head_q, head_d, tail_q, tail_d, rsp_entry;
    logic            imem_read_q, imem_read_d;
    logic [XLEN-1:0] imem_address_q, imem_address_d;
    logic            out_valid_q, out_valid_d;
    logic            pop, push;

    // Next-state, queue and registered-output computation
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        push       = 1'b0;
        pop        = (count_q != '0) && !stall;
        count_pop  = count_q - CNT_W'(pop);
        rsp_entry  = {fetch_pc_q, imem_rdata};

        if (redirect) begin
            // Flush wins over a same-cycle response; a read still in flight must be drained
            count_d    = '0;
            fetch_pc_d = redirect_pc & ~XLEN'(32'd3);
            state_d    = (state_q != S_IDLE && !imem_resp) ? S_DROP : S_FETCH;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (count_q < CNT_W'(DEPTH)) state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_resp) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + XLEN'(32'd4);
                        // Keep fetching only while the queue still has room after this push
                        state_d    = (count_pop == '0) ? S_FETCH : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (imem_resp) state_d = S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase

            if (pop) head_d = tail_q;
            if (push) begin
                if (count_pop == '0) head_d = rsp_entry;
                else                 tail_d = rsp_entry;
            end
            count_d = count_pop + CNT_W'(push);
        end

        imem_read_d    = (state_d != S_IDLE);
        imem_address_d = (state_d == S_DROP) ? imem_address_q : fetch_pc_d;
        out_valid_d    = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            fetch_pc_q     <= RESET_PC;
            head_q         <= '0;
            tail_q         <= '0;
            imem_read_q    <= 1'b0;
            imem_address_q <= RESET_PC;
            out_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            fetch_pc_q     <= fetch_pc_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            imem_read_q    <= imem_read_d;
            imem_address_q <= imem_address_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign imem_read    = imem_read_q;
    assign imem_address = imem_address_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = head_q.pc;
    assign out_inst     = head_q.inst;

endmodule
